character_motion: RTL and testbench

//  Consumes the 2-bit action code produced by the button-decoding FSM and turns it into character motion.

---
 rtl/character_motion.sv | 117 +++++++++++
 tb/tb_character_motion.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/character_motion.sv
// Character motion tracker: turns decoded action codes into horizontal position,
// jump height and landing events, advancing one step per game frame tick.
module character_motion #(
    parameter int unsigned X_W      = 8,
    parameter int unsigned Y_W      = 6,
    parameter int unsigned JUMP_H   = 4,
    parameter int unsigned DJUMP_H  = 7,
    parameter int unsigned RUN_STEP = 1
) (
    input  logic           clk,
    input  logic           reset_n,
    input  logic           tick,
    input  logic [1:0]     action,
    output logic [X_W-1:0] pos_x,
    output logic [Y_W-1:0] pos_y,
    output logic           airborne,
    output logic           land,
    output logic [7:0]     jump_cnt
);

    localparam logic [1:0] ACT_STAND = 2'b00;
    localparam logic [1:0] ACT_JUMP  = 2'b01;
    localparam logic [1:0] ACT_DJUMP = 2'b10;
    localparam logic [1:0] ACT_RUN   = 2'b11;

    localparam logic [Y_W-1:0] JUMP_T  = Y_W'(JUMP_H);
    localparam logic [Y_W-1:0] DJUMP_T = Y_W'(DJUMP_H);
    localparam logic [Y_W-1:0] Y_ONE   = Y_W'(1);

    typedef enum logic [1:0] {
        GROUND = 2'd0,
        RISE   = 2'd1,
        FALL   = 2'd2
    } phase_t;

    phase_t         phase, phase_nxt;
    logic [Y_W-1:0] target, target_nxt;
    logic [X_W-1:0] pos_x_nxt;
    logic [Y_W-1:0] pos_y_nxt;
    logic [7:0]     jump_cnt_nxt;
    logic           land_nxt;

    // State and registered outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            phase    <= GROUND;
            target   <= JUMP_T;
            pos_x    <= '0;
            pos_y    <= '0;
            airborne <= 1'b0;
            land     <= 1'b0;
            jump_cnt <= '0;
        end else begin
            phase    <= phase_nxt;
            target   <= target_nxt;
            pos_x    <= pos_x_nxt;
            pos_y    <= pos_y_nxt;
            airborne <= (phase_nxt != GROUND);
            land     <= land_nxt;
            jump_cnt <= jump_cnt_nxt;
        end
    end

    // Next-state: horizontal step plus GROUND/RISE/FALL vertical machine, only on ticks
    always_comb begin
        phase_nxt    = phase;
        target_nxt   = target;
        pos_x_nxt    = pos_x;
        pos_y_nxt    = pos_y;
        jump_cnt_nxt = jump_cnt;
        land_nxt     = 1'b0;

        if (tick) begin
            if (action == ACT_RUN) begin
                pos_x_nxt = pos_x + X_W'(RUN_STEP);
            end

            case (phase)
                GROUND: begin
                    if (action == ACT_JUMP || action == ACT_DJUMP) begin
                        target_nxt = (action == ACT_DJUMP) ? DJUMP_T : JUMP_T;
                        pos_y_nxt  = Y_ONE;
                        if (jump_cnt != 8'hff) begin
                            jump_cnt_nxt = jump_cnt + 8'd1;
                        end
                        phase_nxt = (target_nxt == Y_ONE) ? FALL : RISE;
                    end
                end
                RISE: begin
                    // A double-jump press while rising raises the apex once
                    if (action == ACT_DJUMP && target == JUMP_T) begin
                        target_nxt = DJUMP_T;
                    end
                    pos_y_nxt = pos_y + Y_ONE;
                    if (pos_y_nxt == target_nxt) begin
                        phase_nxt = FALL;
                    end
                end
                FALL: begin
                    pos_y_nxt = pos_y - Y_ONE;
                    if (pos_y_nxt == '0) begin
                        phase_nxt  = GROUND;
                        land_nxt   = 1'b1;
                        target_nxt = JUMP_T;
                    end
                end
                default: begin
                    phase_nxt = GROUND;
                end
            endcase
        end
    end

    logic unused_stand;
    assign unused_stand = (action == ACT_STAND);

endmodule

// File: tb/tb_character_motion.sv
// Self-checking bench for character_motion: table of frame vectors fed through a
// scoreboard queue, plus hand-written tick-gap, async-reset and saturation sequences.
module tb_character_motion;

    localparam logic [1:0] S  = 2'b00;
    localparam logic [1:0] J  = 2'b01;
    localparam logic [1:0] DJ = 2'b10;
    localparam logic [1:0] R  = 2'b11;

    typedef struct packed {
        logic [7:0] x;
        logic [5:0] y;
        logic       air;
        logic       land;
        logic [7:0] cnt;
    } exp_t;

    typedef struct {
        logic       t;
        logic [1:0] a;
        exp_t       e;
    } vec_t;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       tick = 1'b0;
    logic [1:0] action = 2'b00;
    logic [7:0] pos_x;
    logic [5:0] pos_y;
    logic       airborne;
    logic       land;
    logic [7:0] jump_cnt;

    int total = 0;
    int bad = 0;

    vec_t tbl[$];
    exp_t sbq[$];

    character_motion dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .tick     (tick),
        .action   (action),
        .pos_x    (pos_x),
        .pos_y    (pos_y),
        .airborne (airborne),
        .land     (land),
        .jump_cnt (jump_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    function automatic exp_t mk(input int x, input int y, input bit air, input bit ld, input int cnt);
        exp_t e;
        e.x = 8'(x);
        e.y = 6'(y);
        e.air = air;
        e.land = ld;
        e.cnt = 8'(cnt);
        return e;
    endfunction

    function automatic void add(input logic t, input logic [1:0] a,
                                input int x, input int y, input bit air, input bit ld, input int cnt);
        vec_t v;
        v.t = t;
        v.a = a;
        v.e = mk(x, y, air, ld, cnt);
        tbl.push_back(v);
    endfunction

    task automatic check(input string name, input exp_t e);
        exp_t got;
        got = {pos_x, pos_y, airborne, land, jump_cnt};
        total++;
        if (got !== e) begin
            bad++;
            $display("FAIL %s: got x=%0d y=%0d air=%0b land=%0b cnt=%0d, want x=%0d y=%0d air=%0b land=%0b cnt=%0d",
                     name, got.x, got.y, got.air, got.land, got.cnt,
                     e.x, e.y, e.air, e.land, e.cnt);
        end
    endtask

    // Drive one frame at negedge, push its expectation, compare just after the edge
    task automatic step(input logic t, input logic [1:0] a, input exp_t e, input string name);
        @(negedge clk);
        tick = t;
        action = a;
        sbq.push_back(e);
        @(posedge clk);
        #1;
        if (sbq.size() == 0) begin
            total++;
            bad++;
            $display("FAIL %s: scoreboard empty", name);
        end else begin
            check(name, sbq.pop_front());
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        tick = 1'b0;
        action = S;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        // Basic JUMP then STAND, then a tick-less edge clears land
        add(1, J, 0, 1, 1, 0, 1);
        for (int y = 2; y <= 4; y++) add(1, S, 0, y, 1, 0, 1);
        for (int y = 3; y >= 1; y--) add(1, S, 0, y, 1, 0, 1);
        add(1, S, 0, 0, 0, 1, 1);
        add(0, J, 0, 0, 0, 0, 1);
        // DOUBLE_JUMP from ground: apex 7, lands on tick 14
        add(1, DJ, 0, 1, 1, 0, 2);
        for (int y = 2; y <= 7; y++) add(1, S, 0, y, 1, 0, 2);
        for (int y = 6; y >= 1; y--) add(1, S, 0, y, 1, 0, 2);
        add(1, S, 0, 0, 0, 1, 2);
        add(1, S, 0, 0, 0, 0, 2);
        // JUMP upgraded to double jump mid-rise; later DJ presses ignored
        add(1, J, 0, 1, 1, 0, 3);
        add(1, DJ, 0, 2, 1, 0, 3);
        add(1, S, 0, 3, 1, 0, 3);
        add(1, S, 0, 4, 1, 0, 3);
        add(1, DJ, 0, 5, 1, 0, 3);
        add(1, S, 0, 6, 1, 0, 3);
        add(1, S, 0, 7, 1, 0, 3);
        add(1, DJ, 0, 6, 1, 0, 3);
        for (int y = 5; y >= 1; y--) add(1, DJ, 0, y, 1, 0, 3);
        add(1, S, 0, 0, 0, 1, 3);
        // RUN to wrap pos_x, then RUN during a jump
        for (int i = 1; i <= 254; i++) add(1, R, i, 0, 0, 0, 3);
        add(1, R, 255, 0, 0, 0, 3);
        add(1, R, 0, 0, 0, 0, 3);
        add(1, R, 1, 0, 0, 0, 3);
        add(1, J, 1, 1, 1, 0, 4);
        add(1, R, 2, 2, 1, 0, 4);
        add(1, R, 3, 3, 1, 0, 4);
        add(1, R, 4, 4, 1, 0, 4);
        add(1, R, 5, 3, 1, 0, 4);
        add(1, R, 6, 2, 1, 0, 4);
        add(1, R, 7, 1, 1, 0, 4);
        add(1, R, 8, 0, 0, 1, 4);
        add(1, S, 8, 0, 0, 0, 4);
        // JUMP held: landing tick does not take off, next tick does
        for (int y = 1; y <= 4; y++) add(1, J, 8, y, 1, 0, 5);
        for (int y = 3; y >= 1; y--) add(1, J, 8, y, 1, 0, 5);
        add(1, J, 8, 0, 0, 1, 5);
        add(1, J, 8, 1, 1, 0, 6);

        do_reset();
        #1;
        check("reset_state", mk(0, 0, 0, 0, 0));

        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i].t, tbl[i].a, tbl[i].e, $sformatf("vec%0d", i));
        end

        // tick=0 gaps freeze everything regardless of action
        step(0, J,  mk(8, 1, 1, 0, 6), "gap_jump");
        step(0, DJ, mk(8, 1, 1, 0, 6), "gap_djump");
        step(0, R,  mk(8, 1, 1, 0, 6), "gap_run");
        step(1, S,  mk(8, 2, 1, 0, 6), "resume_2");
        step(1, S,  mk(8, 3, 1, 0, 6), "resume_3");

        // Asynchronous reset mid-rise takes effect before the next clock edge
        #2;
        reset_n = 1'b0;
        #1;
        check("async_reset_immediate", mk(0, 0, 0, 0, 0));
        @(posedge clk);
        #1;
        check("async_reset_held", mk(0, 0, 0, 0, 0));
        @(negedge clk);
        reset_n = 1'b1;
        step(1, S, mk(0, 0, 0, 0, 0), "post_reset_stand");
        // Target must be back to the single-jump apex
        step(1, J, mk(0, 1, 1, 0, 1), "post_reset_j1");
        step(1, S, mk(0, 2, 1, 0, 1), "post_reset_j2");
        step(1, S, mk(0, 3, 1, 0, 1), "post_reset_j3");
        step(1, S, mk(0, 4, 1, 0, 1), "post_reset_j4");
        step(1, S, mk(0, 3, 1, 0, 1), "post_reset_apex");

        // jump_cnt saturation: 260 takeoffs with JUMP held
        do_reset();
        @(negedge clk);
        tick = 1'b1;
        action = J;
        repeat (8 * 260) @(posedge clk);
        #1;
        total++;
        if (jump_cnt !== 8'd255) begin
            bad++;
            $display("FAIL jump_cnt_saturate: got %0d want 255", jump_cnt);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
